// File: rtl/pri_event_pkg.sv
// Shared definitions for the pri_event_encoder block.
package pri_event_pkg;

  // Default number of request lines.
  localparam int N_DEFAULT = 4;

  // IDLE: nothing presented (valid = 0). PRESENT: code holds an event (valid = 1).
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/pri_sel.sv
// Combinational highest-set-bit selector: strict priority, highest index wins.
module pri_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_vec,
  output logic [$clog2(N)-1:0] o_index,
  output logic [N-1:0]         o_onehot,
  output logic                 o_any
);

  localparam int W = $clog2(N);

  // Ascending scan so the last (highest) set bit overwrites any lower one.
  always_comb begin
    o_index  = '0;
    o_any    = |i_vec;
    for (int k = 0; k < N; k++) begin
      if (i_vec[k]) o_index = W'(k);
    end
    o_onehot = o_any ? (N'(1) << o_index) : '0;
  end

endmodule

// File: rtl/pri_event_encoder.sv
// Sequential priority encoder: captures event pulses into a pending set and
// presents them one at a time, highest index first.
//
// Handshake: an event is transferred on a rising edge where valid && ready;
// code is stable while valid is high and ready is low; ready is ignored while
// valid is low.
module pri_event_encoder
  import pri_event_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         ovf
);

  state_t       r_state;
  state_t       w_next_state;
  logic [N-1:0] r_pend;
  logic [N-1:0] w_next_pend;
  logic [W-1:0] r_code;
  logic [W-1:0] w_next_code;
  logic         r_ovf;

  logic [N-1:0] w_merged;
  logic [W-1:0] w_index;
  logic [N-1:0] w_onehot;
  logic         w_any;
  logic         w_load;
  logic [N-1:0] w_grant;
  logic         w_ovf_hit;

  // Merged is formed before the grant clears its bit, so a request for the
  // bit being granted re-enters the pending set instead of being lost.
  assign w_merged = r_pend | req;

  pri_sel #(.N(N)) u_sel (
    .i_vec    (w_merged),
    .o_index  (w_index),
    .o_onehot (w_onehot),
    .o_any    (w_any)
  );

  // A new event may be loaded when idle or when the presented one is accepted.
  assign w_load    = (r_state == IDLE) || ready;
  assign w_grant   = (w_load && w_any) ? w_onehot : '0;
  // Loss only when a request hits a bit already pending and not granted now.
  assign w_ovf_hit = |(req & r_pend & ~w_grant);

  // Next-state, next pending set and next code.
  always_comb begin
    w_next_state = r_state;
    w_next_pend  = r_pend;
    w_next_code  = r_code;
    if (w_load) begin
      if (w_any) begin
        w_next_state = PRESENT;
        w_next_pend  = w_merged & ~w_onehot;
        w_next_code  = w_index;
      end else begin
        w_next_state = IDLE;
        w_next_pend  = '0;
      end
    end else begin
      w_next_pend = r_pend | req;
    end
  end

  // State, pending set, code and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_code  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pend  <= w_next_pend;
      r_code  <= w_next_code;
      r_ovf   <= r_ovf | w_ovf_hit;
    end
  end

  assign code    = r_code;
  assign valid   = (r_state == PRESENT);
  assign pending = r_pend;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_pri_event_encoder.sv
// Bench for pri_event_encoder: directed scenarios plus random traffic,
// checked against a set-based reference model and an expected-code queue.
module tb_pri_event_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] code;
  logic       valid;
  logic       ready;
  logic [3:0] pending;
  logic       ovf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_q[$];

  // Reference model state.
  logic [3:0] m_pend;
  logic [1:0] m_code;
  logic       m_valid;
  logic       m_ovf;

  pri_event_encoder #(.N(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .pending (pending),
    .ovf     (ovf)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pend  = 4'b0;
    m_code  = 2'd0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, then compare.
  task automatic step(input logic [3:0] r, input logic rd);
    logic [3:0] merged;
    int         sel;
    bit         load;
    req   = r;
    ready = rd;
    load   = !m_valid || (rd == 1'b1);
    merged = m_pend | r;
    sel    = -1;
    for (int k = 3; k >= 0; k--) if (merged[k] && sel < 0) sel = k;
    for (int k = 0; k < 4; k++)
      if (r[k] && m_pend[k] && !(load && k == sel)) m_ovf = 1'b1;
    if (load) begin
      if (sel >= 0) begin
        m_code  = 2'(sel);
        m_valid = 1'b1;
        merged[sel] = 1'b0;
        m_pend  = merged;
        exp_q.push_back(2'(sel));
      end else begin
        m_valid = 1'b0;
        m_pend  = 4'b0;
      end
    end else begin
      m_pend = m_pend | r;
    end
    @(posedge clk);
    #1;
    req = 4'b0;
    check("valid",   32'(valid),   32'(m_valid));
    check("code",    32'(code),    32'(m_code));
    check("pending", 32'(pending), 32'(m_pend));
    check("ovf",     32'(ovf),     32'(m_ovf));
  endtask

  // Monitor: an event accepted on the coming edge must be the oldest expected code.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("accept_unexpected", 32'(code), 32'hFFFF_FFFF);
      end else begin
        check("accept_code", 32'(code), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req   = 4'b0;
    ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_code",  32'(code),  32'd0);
    check("rst_pend",  32'(pending), 32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous requests drain 3, 1, 0 back to back.
    step(4'b1011, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("simul_idle", 32'(valid), 32'd0);

    // Backpressure holds code 2, then accept.
    step(4'b0100, 1'b0);
    repeat (4) step(4'b0000, 1'b0);
    check("bp_code_held", 32'(code), 32'd2);
    step(4'b0000, 1'b1);
    check("bp_idle", 32'(valid), 32'd0);

    // Preemption: higher request waits behind the presented code 1.
    step(4'b0010, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b1);
    check("pre_code3", 32'(code), 32'd3);
    check("pre_pend0", 32'(pending), 32'd0);
    step(4'b0000, 1'b1);

    // Re-request of the granted bit is delivered twice, no overflow.
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    check("rereq_ovf", 32'(ovf), 32'd0);

    // Overflow: pend holds bit 0 while code 3 is presented.
    step(4'b1001, 1'b0);
    step(4'b0001, 1'b0);
    check("ovf_set", 32'(ovf), 32'd1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Asynchronous reset mid-handshake with pend = 1010.
    step(4'b1000, 1'b0);
    step(4'b1010, 1'b0);
    check("pre_rst_pend", 32'(pending), 32'hA);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_valid", 32'(valid),   32'd0);
    check("arst_code",  32'(code),    32'd0);
    check("arst_pend",  32'(pending), 32'd0);
    check("arst_ovf",   32'(ovf),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      step(r, ($urandom_range(0, 3) != 0));
    end

    // Drain with ready high, bounded.
    for (int i = 0; i < 20; i++) begin
      if (m_valid || m_pend != 4'b0) step(4'b0000, 1'b1);
    end
    check("drain_idle",  32'(valid), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
